seq_bidirec_shifter: RTL and testbench



---
 rtl/shifter_pkg.sv | 16 +
 rtl/shift_step.sv | 23 ++
 rtl/seq_bidirec_shifter.sv | 117 +++++++++++
 tb/tb_seq_bidirec_shifter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types and defaults for the iterative bidirectional shifter.
package shifter_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int SHW_DEF   = 3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Single-bit shift step: left with zero fill, right with optional sign fill.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] val,
  input  logic             dir,
  input  logic             arith,
  output logic [WIDTH-1:0] nxt
);

  // One position per call; the sign bit is re-read from val each step
  always_comb begin
    nxt = val;
    case (dir)
      DIR_LEFT:  nxt = {val[WIDTH-2:0], 1'b0};
      DIR_RIGHT: nxt = {arith & val[WIDTH-1], val[WIDTH-1:1]};
      default:   nxt = val;
    endcase
  end

endmodule

// File: rtl/seq_bidirec_shifter.sv
// Multi-cycle bidirectional shifter: one bit per clock under a start/done handshake.
module seq_bidirec_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shamt,
  input  logic             dir,
  input  logic             arith,
  output logic [WIDTH-1:0] out,
  output logic             ready,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             arith_q, arith_d;
  logic [WIDTH-1:0] step_s;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .val   (out_q),
    .dir   (dir_q),
    .arith (arith_q),
    .nxt   (step_s)
  );

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
    end
  end

  // Next-state logic; a zero shift amount skips SHIFT entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (shamt == SHW'(0)) ? DONE : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_q == SHW'(1)) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accepted start, step and count down while shifting
  always_comb begin
    out_d   = out_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    arith_d = arith_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          out_d   = in;
          cnt_d   = shamt;
          dir_d   = dir;
          arith_d = arith;
        end else begin
          out_d   = out_q;
        end
      end
      SHIFT: begin
        out_d = step_s;
        cnt_d = cnt_q - SHW'(1);
      end
      default: begin
        out_d = out_q;
      end
    endcase
  end

  // Handshake outputs decoded from the registered state
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      IDLE:    ready = 1'b1;
      SHIFT:   busy  = 1'b1;
      DONE:    done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign out = out_q;

endmodule

// File: tb/tb_seq_bidirec_shifter.sv
// Self-checking bench: per-cycle comparison against an arithmetic shift model plus directed literals.
module tb_seq_bidirec_shifter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_s = 1'b0;
  logic [7:0] in_s = 8'd0;
  logic [2:0] shamt_s = 3'd0;
  logic       dir_s = 1'b0;
  logic       arith_s = 1'b0;
  logic [7:0] out_s;
  logic       ready_s, busy_s, done_s;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  seq_bidirec_shifter #(.WIDTH(8), .SHW(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start_s),
    .in    (in_s),
    .shamt (shamt_s),
    .dir   (dir_s),
    .arith (arith_s),
    .out   (out_s),
    .ready (ready_s),
    .busy  (busy_s),
    .done  (done_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // n-step result from plain shift operators
  function automatic logic [7:0] shift_ref(input logic [7:0] v, input int n,
                                           input logic d, input logic a);
    logic signed [7:0] s;
    s = v;
    if (!d) return v << n;
    else if (a) return s >>> n;
    else return v >> n;
  endfunction

  // Model: after accept at edge k, the value after edge e is shift_ref(in, e-k)
  int         ec = 0;
  bit         m_valid = 0;
  bit         m_act = 0;
  int         m_k = 0;
  logic [7:0] m_in, m_out;
  int         m_sh;
  logic       m_dir, m_ar;
  logic       e_ready, e_busy, e_done;
  logic [7:0] e_out;

  initial begin
    forever begin
      @(posedge clk);
      ec++;
      if (rst) begin
        m_act = 0;
        m_out = 8'd0;
        m_valid = 1;
      end else if (!m_act) begin
        if (start_s) begin
          m_act = 1; m_k = ec; m_in = in_s; m_sh = int'(shamt_s);
          m_dir = dir_s; m_ar = arith_s;
        end
      end else if (ec - m_k == m_sh + 1) begin
        m_act = 0;
      end
      if (m_act) begin
        e_out = shift_ref(m_in, ec - m_k, m_dir, m_ar);
        e_busy = (ec - m_k) < m_sh;
        e_done = (ec - m_k) == m_sh;
        e_ready = 1'b0;
        m_out = e_out;
      end else begin
        e_out = m_out; e_busy = 1'b0; e_done = 1'b0; e_ready = 1'b1;
      end
    end
  end

  // Compare process on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("cyc_out", int'(out_s), int'(e_out));
        chk("cyc_ready", int'(ready_s), int'(e_ready));
        chk("cyc_busy", int'(busy_s), int'(e_busy));
        chk("cyc_done", int'(done_s), int'(e_done));
        if (done_s === 1'b1) done_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one operation; returns cycles to done, busy-seen flag and out in cycle 2
  task automatic run_op(input logic [7:0] v, input logic [2:0] sh, input logic d,
                        input logic a, output int lat, output bit saw_busy,
                        output logic [7:0] out_c2);
    in_s = v; shamt_s = sh; dir_s = d; arith_s = a; start_s = 1'b1;
    tick();
    start_s = 1'b0; in_s = 8'hAA;
    lat = -1; saw_busy = 0; out_c2 = 8'hXX;
    for (int i = 1; i <= 20; i++) begin
      if (busy_s) saw_busy = 1;
      if (i == 2) out_c2 = out_s;
      if (done_s) begin
        lat = i;
        break;
      end
      tick();
    end
    chk("done_timeout", int'(lat > 0), 1);
  endtask

  int lat;
  bit sb;
  logic [7:0] c2;
  int dc0;

  initial begin
    chk("model_pin_l", int'(shift_ref(8'd5, 4, 1'b0, 1'b0)), 8'b01010000);
    chk("model_pin_a", int'(shift_ref(8'd128, 2, 1'b1, 1'b1)), 8'b11100000);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out", int'(out_s), 0);
    chk("rst_ready", int'(ready_s), 1);
    chk("rst_busy", int'(busy_s), 0);
    chk("rst_done", int'(done_s), 0);
    tick();

    // 1: left by 4
    run_op(8'd5, 3'd4, 1'b0, 1'b0, lat, sb, c2);
    chk("t1_lat", lat, 5);
    chk("t1_out", int'(out_s), 8'b01010000);
    tick();
    chk("t1_ready_back", int'(ready_s), 1);

    // 2: logical right by 3
    run_op(8'd30, 3'd3, 1'b1, 1'b0, lat, sb, c2);
    chk("t2_step1", int'(c2), 8'b00001111);
    chk("t2_out", int'(out_s), 8'b00000011);
    chk("t2_lat", lat, 4);
    tick();

    // 3: arithmetic vs logical right of the sign bit
    run_op(8'd128, 3'd2, 1'b1, 1'b1, lat, sb, c2);
    chk("t3_arith", int'(out_s), 8'b11100000);
    tick();
    run_op(8'd128, 3'd2, 1'b1, 1'b0, lat, sb, c2);
    chk("t3_logic", int'(out_s), 8'b00100000);
    tick();

    // 4: zero shift
    run_op(8'd63, 3'd0, 1'b1, 1'b0, lat, sb, c2);
    chk("t4_lat", lat, 1);
    chk("t4_out", int'(out_s), 8'b00111111);
    chk("t4_nobusy", int'(sb), 0);
    tick();
    chk("t4_hold", int'(out_s), 8'b00111111);

    // 5: start during SHIFT is ignored
    dc0 = done_cnt;
    in_s = 8'd52; shamt_s = 3'd7; dir_s = 1'b0; arith_s = 1'b0; start_s = 1'b1;
    tick();
    in_s = 8'hFF; shamt_s = 3'd1; start_s = 1'b1;
    tick();
    start_s = 1'b0;
    lat = -1;
    for (int i = 2; i <= 20; i++) begin
      if (done_s) begin
        lat = i;
        break;
      end
      tick();
    end
    chk("t5_lat", lat, 8);
    chk("t5_out", int'(out_s), 8'b00000000);
    tick(); tick(); tick();
    chk("t5_one_done", done_cnt - dc0, 1);

    // 6: reset during SHIFT aborts without done
    dc0 = done_cnt;
    in_s = 8'd25; shamt_s = 3'd5; dir_s = 1'b1; arith_s = 1'b0; start_s = 1'b1;
    tick();
    start_s = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_out", int'(out_s), 0);
    chk("t6_ready", int'(ready_s), 1);
    chk("t6_busy", int'(busy_s), 0);
    chk("t6_done", int'(done_s), 0);
    for (int i = 0; i < 6; i++) tick();
    chk("t6_no_done", done_cnt - dc0, 0);
    run_op(8'd25, 3'd3, 1'b1, 1'b0, lat, sb, c2);
    chk("t6_after", int'(out_s), 8'b00000011);
    chk("t6_after_lat", lat, 4);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
